note_sequencer_arb: RTL
=======================

// Module: note_sequencer_arb
// PURPOSE
//  Drives note_gen: steps a two-channel score held in an external synchronous ROM
//  at a fixed beat rate and presents note_div_left/right and volume each clock.
//  Arbitrates one sound-effect (SFX) requester, which preempts the score and then
//  resumes it. Divider value 22'd1 means silence on that channel.
// PARAMETERS
//  BEAT_DIV  25_000_000  clk cycles per beat (0.25 s at 100 MHz); must be >= 2
//  SCORE_AW  7           score ROM address width
// PORTS
//  clk             in   1         system clock
//  rst             in   1         reset, asynchronous, active-high
//  play            in   1         level; 1 = run score, 0 = pause
//  restart         in   1         1-cycle pulse; rewind score to address 0
//  score_len       in   SCORE_AW  number of score entries; 0 = empty score
//  score_addr      out  SCORE_AW  ROM address (registered)
//  score_data      in   44        {left_div[43:22], right_div[21:0]}; valid 1 cycle after addr
//  volume_in       in   2         user volume setting
//  sfx_req         in   1         SFX request level; sampled each clk
//  sfx_div         in   22        SFX divider, applied to both channels
//  sfx_beats       in   4         SFX length in beats; 0 is treated as 1
//  sfx_ack         out  1         1-cycle pulse when request is accepted
//  sfx_busy        out  1         high while SFX is playing
//  note_div_left   out  22        to note_gen
//  note_div_right  out  22        to note_gen
//  volume          out  2         to note_gen
// BEHAVIOUR
//  - Reset: state IDLE; score_addr=0, beat_cnt=0, note regs=22'd1, note_div_*=22'd1,
//    volume=0, sfx_ack=0, sfx_busy=0. All outputs registered.
//  - States: IDLE, FETCH, WAIT, PLAY, SFX.
//    IDLE : play=1 and score_len!=0 -> FETCH. Otherwise stay.
//    FETCH: score_addr is stable; the ROM samples it -> WAIT.
//    WAIT : latch score_data into note regs; beat_cnt=0 -> PLAY.
//    PLAY : play=1: beat_cnt++; at beat_cnt==BEAT_DIV-1, addr+1 (wraps to 0 at
//           score_len-1) -> FETCH. play=0: beat_cnt and addr held (pause).
//  - Note period is BEAT_DIV+2 cycles: FETCH + WAIT + BEAT_DIV PLAY cycles.
//    Outputs keep the previous note during FETCH and WAIT (no glitch to silence).
//  - Outputs in PLAY/FETCH/WAIT with play=1: note regs and volume=volume_in.
//    With play=0 or in IDLE: divs=22'd1 and volume=0.
//  - SFX: if sfx_req=1 and state!=SFX, the request is accepted in any state.
//    sfx_ack pulses for 1 cycle; sfx_div and max(sfx_beats,1) are latched.
//    The return state is saved: PLAY->PLAY, FETCH/WAIT->FETCH, IDLE->IDLE.
//    Music addr, beat_cnt and note regs are frozen during SFX.
//    In SFX: both divs=sfx_div, volume=volume_in, sfx_busy=1. This applies regardless
//    of play. A private counter runs for beats*BEAT_DIV cycles; then the block
//    returns to the saved state and sfx_busy falls.
//  - sfx_req during SFX: ignored, no ack. A held req is re-accepted on the first
//    cycle after return, so it is level-sensitive.
//  - restart: addr=0, beat_cnt=0. Outside SFX -> FETCH if play and score_len!=0,
//    else IDLE. During SFX: the rewind applies now and the return state becomes
//    FETCH/IDLE by the same rule. restart and sfx_req in the same cycle: both take
//    effect; SFX is entered and the return state follows the restart rule.
//  - score_len drops to <= addr: addr wraps to 0 at the next advance.
//    score_len=0: return to IDLE at the next advance.
//  - Asynchronous rst mid-operation: immediate return to reset values; any
//    in-flight SFX is dropped without an ack.
// TESTING (BEAT_DIV=4, SCORE_AW=3)
//  1 Reset: pulse rst mid-PLAY -> same cycle divs=1, volume=0, score_addr=0, busy=0.
//  2 score_len=3, ROM[0..2]=A,B,C, play=1 -> addr 0,1,2,0 each 6 cycles; divs
//    switch to A/B/C 2 cycles after each addr change; volume=volume_in.
//  3 Pause after 2 PLAY cycles of B -> divs=1, volume=0; resume -> B for 2 more
//    cycles, then addr=2.
//  4 sfx_req with div=1000, beats=2 during B -> ack 1 cycle, busy 8 cycles,
//    divs=1000; then B resumes with its remaining beat count.
//  5 sfx_beats=0 -> busy 4 cycles. Second req during SFX -> no ack; held req
//    re-acked right after return.
//  6 restart during SFX -> SFX completes, then FETCH at addr 0 -> A. score_len=0
//    with play=1 -> stays IDLE, silent.

Source files
------------

// File: rtl/note_sequencer_arb.sv
// note_sequencer_arb
//   Steps a two-channel score from an external synchronous ROM at a fixed beat
//   rate and drives note_gen. One SFX requester can preempt the score; the
//   score then resumes where it left off.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   play, restart       run/pause level; one-cycle rewind pulse
//   score_len           number of score entries (0 = empty)
//   score_addr          registered ROM address
//   score_data          {left_div, right_div}, valid one cycle after score_addr
//   volume_in           user volume
//   sfx_req/div/beats   SFX request level, divider, length in beats
//   sfx_ack, sfx_busy   accept pulse, SFX active
//   note_div_left/right divider outputs (22'd1 = silence)
//   volume              volume output
module note_sequencer_arb #(
    parameter int unsigned BEAT_DIV = 25_000_000,
    parameter int unsigned SCORE_AW = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play,
    input  logic                restart,
    input  logic [SCORE_AW-1:0] score_len,
    output logic [SCORE_AW-1:0] score_addr,
    input  logic [43:0]         score_data,
    input  logic [1:0]          volume_in,
    input  logic                sfx_req,
    input  logic [21:0]         sfx_div,
    input  logic [3:0]          sfx_beats,
    output logic                sfx_ack,
    output logic                sfx_busy,
    output logic [21:0]         note_div_left,
    output logic [21:0]         note_div_right,
    output logic [1:0]          volume
);

    localparam int unsigned BW = $clog2(BEAT_DIV);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEAT_DIV - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_PLAY, ST_SFX} state_t;

    state_t              state, state_n, ret_state, ret_n;
    logic [SCORE_AW-1:0] addr_n;
    logic [BW-1:0]       beat_cnt, beat_n;
    logic [21:0]         note_l, note_l_n, note_r, note_r_n;
    logic [21:0]         sfx_div_q, sfx_div_n;
    logic [3:0]          sfx_left, sfx_left_n;
    logic [BW-1:0]       sfx_sub, sfx_sub_n;
    logic                accept, ack_n, busy_n;
    logic [21:0]         div_l_n, div_r_n;
    logic [1:0]          vol_n;
    state_t              rewind_state;

    assign accept       = sfx_req && (state != ST_SFX);
    assign rewind_state = (play && score_len != '0) ? ST_FETCH : ST_IDLE;

    always_comb begin
        state_n    = state;
        ret_n      = ret_state;
        addr_n     = score_addr;
        beat_n     = beat_cnt;
        note_l_n   = note_l;
        note_r_n   = note_r;
        sfx_div_n  = sfx_div_q;
        sfx_left_n = sfx_left;
        sfx_sub_n  = sfx_sub;

        if (state == ST_SFX) begin
            if (restart) begin
                addr_n = '0;
                beat_n = '0;
                ret_n  = rewind_state;
            end
            if (sfx_sub == LAST_BEAT) begin
                sfx_sub_n = '0;
                if (sfx_left == 4'd1) state_n = ret_n;
                else                  sfx_left_n = sfx_left - 4'd1;
            end else begin
                sfx_sub_n = sfx_sub + BW'(1);
            end
        end else if (accept) begin
            // The accept cycle preempts this cycle's music step, so the
            // interrupted note later resumes at the same beat count.
            state_n    = ST_SFX;
            sfx_div_n  = sfx_div;
            sfx_left_n = (sfx_beats == 4'd0) ? 4'd1 : sfx_beats;
            sfx_sub_n  = '0;
            if (restart) begin
                addr_n = '0;
                beat_n = '0;
                ret_n  = rewind_state;
            end else begin
                case (state)
                    ST_PLAY: ret_n = ST_PLAY;
                    ST_IDLE: ret_n = ST_IDLE;
                    default: ret_n = ST_FETCH;
                endcase
            end
        end else if (restart) begin
            addr_n  = '0;
            beat_n  = '0;
            state_n = rewind_state;
        end else begin
            case (state)
                ST_IDLE:  if (play && score_len != '0) state_n = ST_FETCH;
                ST_FETCH: state_n = ST_WAIT;
                ST_WAIT: begin
                    note_l_n = score_data[43:22];
                    note_r_n = score_data[21:0];
                    beat_n   = '0;
                    state_n  = ST_PLAY;
                end
                ST_PLAY: begin
                    if (play) begin
                        if (beat_cnt == LAST_BEAT) begin
                            beat_n = '0;
                            if (score_len == '0) begin
                                addr_n  = '0;
                                state_n = ST_IDLE;
                            end else begin
                                // >= also catches a score_len shrunk below addr
                                if (score_addr >= score_len - SCORE_AW'(1)) addr_n = '0;
                                else addr_n = score_addr + SCORE_AW'(1);
                                state_n = ST_FETCH;
                            end
                        end else begin
                            beat_n = beat_cnt + BW'(1);
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with
    // the state they describe.
    always_comb begin
        ack_n   = accept;
        busy_n  = (state_n == ST_SFX);
        div_l_n = 22'd1;
        div_r_n = 22'd1;
        vol_n   = '0;
        if (state_n == ST_SFX) begin
            div_l_n = sfx_div_n;
            div_r_n = sfx_div_n;
            vol_n   = volume_in;
        end else if (play && (state_n == ST_FETCH || state_n == ST_WAIT || state_n == ST_PLAY)) begin
            div_l_n = note_l_n;
            div_r_n = note_r_n;
            vol_n   = volume_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            ret_state      <= ST_IDLE;
            score_addr     <= '0;
            beat_cnt       <= '0;
            note_l         <= 22'd1;
            note_r         <= 22'd1;
            sfx_div_q      <= 22'd1;
            sfx_left       <= 4'd1;
            sfx_sub        <= '0;
            sfx_ack        <= 1'b0;
            sfx_busy       <= 1'b0;
            note_div_left  <= 22'd1;
            note_div_right <= 22'd1;
            volume         <= '0;
        end else begin
            state          <= state_n;
            ret_state      <= ret_n;
            score_addr     <= addr_n;
            beat_cnt       <= beat_n;
            note_l         <= note_l_n;
            note_r         <= note_r_n;
            sfx_div_q      <= sfx_div_n;
            sfx_left       <= sfx_left_n;
            sfx_sub        <= sfx_sub_n;
            sfx_ack        <= ack_n;
            sfx_busy       <= busy_n;
            note_div_left  <= div_l_n;
            note_div_right <= div_r_n;
            volume         <= vol_n;
        end
    end

endmodule
